// File: rtl/mul_acc_pkg.sv
// Shared constants for the multiplier APB register block:
// word indices, CTRL/STATUS bit positions and FSM states.
package mul_acc_pkg;

  localparam int IDX_CTRL   = 0;
  localparam int IDX_STATUS = 1;
  localparam int IDX_JOBCNT = 2;

  localparam int CTRL_START = 0;
  localparam int CTRL_MODE  = 1;
  localparam int CTRL_WRT   = 2;
  localparam int CTRL_RDT   = 4;
  localparam int CTRL_IE    = 6;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_CBUSY = 2;

  localparam int JOBCNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2
  } state_e;

endpackage

// File: rtl/mul_apb_regs.sv
// APB register slice (CTRL/STATUS/JOBCNT) and job sequencer for the multiplier.
// Ports: clk_i/rst_ni; APB slave psel/penable/pwrite/paddr/pwdata -> prdata/pready/pslverr;
// job side start_FMEM_o, mod_o, write/read targets, cont_busy_i, write_flag_i, busy_o, irq_o.
module mul_apb_regs
  import mul_acc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BUS_WIDTH   = 64,
  parameter int ADDR_WIDTH  = 16,
  parameter int SP_NTARGETS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [BUS_WIDTH-1:0]  pwdata_i,
  output logic [BUS_WIDTH-1:0]  prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic                  start_FMEM_o,
  output logic                  mod_o,
  output logic [1:0]            write_target_o,
  output logic [1:0]            read_target_c_o,
  input  logic                  cont_busy_i,
  input  logic                  write_flag_i,
  output logic                  busy_o,
  output logic                  irq_o
);

  localparam int SHIFT = $clog2(BUS_WIDTH / 8);

  state_e state_q, state_d;

  logic                  access;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  sel_ctrl;
  logic                  sel_status;
  logic                  sel_jobcnt;
  logic                  sel_bad;
  logic                  ctrl_wr;
  logic                  ctrl_ok;
  logic                  done_clr;
  logic                  done_d;
  logic                  ie_d;
  logic                  busy;
  logic                  launch;
  logic                  finish;
  logic [BUS_WIDTH-1:0]  rdata;

  logic                  mod_q;
  logic [1:0]            wrt_q;
  logic [1:0]            rdt_q;
  logic                  ie_q;
  logic                  done_q;
  logic                  irq_q;
  logic [JOBCNT_W-1:0]   jobcnt_q;

  logic                  unused_bits;

  assign unused_bits = ^{pwdata_i[BUS_WIDTH-1:7],
                         DATA_WIDTH[0], SP_NTARGETS[0]};

  assign access     = psel_i & penable_i;
  assign wr_en      = access & pwrite_i;
  assign idx        = paddr_i >> SHIFT;
  assign sel_ctrl   = (idx == ADDR_WIDTH'(IDX_CTRL));
  assign sel_status = (idx == ADDR_WIDTH'(IDX_STATUS));
  assign sel_jobcnt = (idx == ADDR_WIDTH'(IDX_JOBCNT));
  assign sel_bad    = ~(sel_ctrl | sel_status | sel_jobcnt);

  // CTRL only accepts writes between jobs so targets stay stable
  assign ctrl_wr  = wr_en & sel_ctrl;
  assign ctrl_ok  = ctrl_wr & ~busy;
  assign done_clr = wr_en & sel_status & pwdata_i[ST_DONE];

  // a completion in the same cycle as a W1C keeps DONE set
  assign done_d = finish | (done_q & ~done_clr);
  assign ie_d   = ctrl_ok ? pwdata_i[CTRL_IE] : ie_q;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    launch  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ctrl_ok && pwdata_i[CTRL_START]) begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        busy    = 1'b1;
        launch  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (write_flag_i) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      mod_q    <= 1'b0;
      wrt_q    <= '0;
      rdt_q    <= '0;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      jobcnt_q <= '0;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      irq_q   <= done_d & ie_d;
      if (ctrl_ok) begin
        mod_q <= pwdata_i[CTRL_MODE];
        wrt_q <= pwdata_i[CTRL_WRT +: 2];
        rdt_q <= pwdata_i[CTRL_RDT +: 2];
      end
      if (finish) begin
        jobcnt_q <= jobcnt_q + JOBCNT_W'(1);
      end
    end
  end

  // read mux is gated by reset so the bus sees zero while held
  always_comb begin
    rdata = '0;
    if (access && rst_ni) begin
      unique case (1'b1)
        sel_ctrl: begin
          rdata[CTRL_MODE]     = mod_q;
          rdata[CTRL_WRT +: 2] = wrt_q;
          rdata[CTRL_RDT +: 2] = rdt_q;
          rdata[CTRL_IE]       = ie_q;
        end
        sel_status: begin
          rdata[ST_BUSY]  = busy;
          rdata[ST_DONE]  = done_q;
          rdata[ST_CBUSY] = cont_busy_i;
        end
        sel_jobcnt: rdata[JOBCNT_W-1:0] = jobcnt_q;
        default:    rdata = '0;
      endcase
    end
  end

  assign prdata_o        = rdata;
  assign pready_o        = 1'b1;
  assign pslverr_o       = rst_ni & access & (sel_bad | (ctrl_wr & busy));
  assign start_FMEM_o    = launch;
  assign busy_o          = busy;
  assign mod_o           = mod_q;
  assign write_target_o  = wrt_q;
  assign read_target_c_o = rdt_q;
  assign irq_o           = irq_q;

endmodule
